// File: rtl/adc_sched_pkg.sv
// Shared types and constants for the ADC sample scheduler.
// The optional averaging build (ADC_SCHED_AVG_EN) sizes its accumulators with acc_width().
package adc_sched_pkg;

   localparam int unsigned NUM_CH     = 4;
   localparam int unsigned DATA_W_DEF = 12;
   localparam int unsigned ACC_W      = DATA_W_DEF + 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_CAPTURE   = 3'd4,
      ST_FAULT     = 3'd5
   } sched_state_t;

   // Four samples of dw bits sum without overflow in dw+2 bits.
   function automatic int unsigned acc_width(input int unsigned dw);
      return dw + 2;
   endfunction

endpackage

// File: rtl/adc_sched_tick_gen.sv
// Free-running period counter: counts 0..PERIOD_CYC-1 while enabled and flags the wrap cycle.
module adc_sched_tick_gen #(
   parameter int unsigned PERIOD_CYC = 50000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_enable,
   output logic o_tick
);

   localparam int unsigned CNT_W = $clog2(PERIOD_CYC);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CNT_W'(PERIOD_CYC - 1));
   assign o_tick = i_enable && w_wrap;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (!i_enable || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Triggers the 4-channel SPI ADC engine, waits on its ready handshake with a timeout, and
// publishes captured samples through a valid/ack stage. ADC_SCHED_AVG_EN enables 4x averaging.
module adc_sample_scheduler
   import adc_sched_pkg::*;
#(
   parameter int unsigned PERIOD_CYC  = 50000,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned DATA_W      = DATA_W_DEF
) (
   input  logic              ref_clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              single_shot,
   output logic              spi_start,
   input  logic              spi_ready,
   input  logic [DATA_W-1:0] spi_data0,
   input  logic [DATA_W-1:0] spi_data1,
   input  logic [DATA_W-1:0] spi_data2,
   input  logic [DATA_W-1:0] spi_data3,
   output logic [DATA_W-1:0] sample_ch0,
   output logic [DATA_W-1:0] sample_ch1,
   output logic [DATA_W-1:0] sample_ch2,
   output logic [DATA_W-1:0] sample_ch3,
   output logic              sample_valid,
   input  logic              sample_ack,
   output logic              overrun,
   output logic              timeout_err,
   input  logic              clear_err,
   output logic              busy,
   output logic [2:0]        o_state
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYC);

   sched_state_t      r_state;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_spi_start;
   logic              r_valid;
   logic              r_overrun;
   logic              r_to_err;
   logic              r_busy;
   logic [DATA_W-1:0] r_ch   [NUM_CH];
   logic [DATA_W-1:0] w_data [NUM_CH];
   logic              w_tick;
   logic              w_trigger;
   logic              w_to_expired;

   adc_sched_tick_gen #(
      .PERIOD_CYC (PERIOD_CYC)
   ) u_tick (
      .i_clk    (ref_clk),
      .i_rst_n  (reset_n),
      .i_enable (enable),
      .o_tick   (w_tick)
   );

   assign w_data[0] = spi_data0;
   assign w_data[1] = spi_data1;
   assign w_data[2] = spi_data2;
   assign w_data[3] = spi_data3;

   assign w_trigger    = w_tick | single_shot;
   // Counter is loaded with TIMEOUT_CYC, so a wait state lasts at most TIMEOUT_CYC cycles.
   assign w_to_expired = (r_to_cnt <= TO_W'(1));

`ifdef ADC_SCHED_AVG_EN
   localparam int unsigned AW = acc_width(DATA_W);

   logic [AW-1:0] r_acc [NUM_CH];
   logic [AW-1:0] w_sum [NUM_CH];
   logic [1:0]    r_avg_cnt;

   always_comb begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         w_sum[c] = r_acc[c] + AW'(w_data[c]);
      end
   end
`endif

   always_ff @(posedge ref_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_to_cnt    <= '0;
         r_spi_start <= 1'b0;
         r_valid     <= 1'b0;
         r_overrun   <= 1'b0;
         r_to_err    <= 1'b0;
         r_busy      <= 1'b0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_ch[c] <= '0;
         end
`ifdef ADC_SCHED_AVG_EN
         r_avg_cnt <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_acc[c] <= '0;
         end
`endif
      end else begin
         r_spi_start <= 1'b0;

         // Low-priority updates first; set events in the case below override them.
         if (sample_ack && r_valid) begin
            r_valid <= 1'b0;
         end
         if (clear_err) begin
            r_overrun <= 1'b0;
            r_to_err  <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_trigger && spi_ready) begin
                  r_state     <= ST_START;
                  r_spi_start <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end

            ST_START: begin
               r_to_cnt <= TO_LOAD;
               r_state  <= ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
               if (!spi_ready) begin
                  r_to_cnt <= TO_LOAD;
                  r_state  <= ST_WAIT_DONE;
               end else if (w_to_expired) begin
                  r_state <= ST_FAULT;
               end else begin
                  r_to_cnt <= r_to_cnt - 1'b1;
               end
            end

            ST_WAIT_DONE: begin
               if (spi_ready) begin
                  r_state <= ST_CAPTURE;
               end else if (w_to_expired) begin
                  r_state <= ST_FAULT;
               end else begin
                  r_to_cnt <= r_to_cnt - 1'b1;
               end
            end

            ST_CAPTURE: begin
`ifdef ADC_SCHED_AVG_EN
               r_avg_cnt <= r_avg_cnt + 2'd1;
               if (r_avg_cnt == 2'd3) begin
                  for (int unsigned c = 0; c < NUM_CH; c++) begin
                     r_ch[c]  <= DATA_W'(w_sum[c] >> 2);
                     r_acc[c] <= '0;
                  end
                  r_valid <= 1'b1;
                  if (r_valid && !sample_ack) begin
                     r_overrun <= 1'b1;
                  end
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  // Partial average: chain straight into the next conversion.
                  for (int unsigned c = 0; c < NUM_CH; c++) begin
                     r_acc[c] <= w_sum[c];
                  end
                  r_state     <= ST_START;
                  r_spi_start <= 1'b1;
               end
`else
               for (int unsigned c = 0; c < NUM_CH; c++) begin
                  r_ch[c] <= w_data[c];
               end
               r_valid <= 1'b1;
               if (r_valid && !sample_ack) begin
                  r_overrun <= 1'b1;
               end
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
`endif
            end

            ST_FAULT: begin
               r_to_err <= 1'b1;
               r_state  <= ST_IDLE;
               r_busy   <= 1'b0;
`ifdef ADC_SCHED_AVG_EN
               r_avg_cnt <= '0;
               for (int unsigned c = 0; c < NUM_CH; c++) begin
                  r_acc[c] <= '0;
               end
`endif
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign spi_start    = r_spi_start;
   assign sample_ch0   = r_ch[0];
   assign sample_ch1   = r_ch[1];
   assign sample_ch2   = r_ch[2];
   assign sample_ch3   = r_ch[3];
   assign sample_valid = r_valid;
   assign overrun      = r_overrun;
   assign timeout_err  = r_to_err;
   assign busy         = r_busy;
   assign o_state      = r_state;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler: table of single-shot captures plus hand sequences
// for periodic timing, overrun, busy-drop, timeout (second instance) and async reset.
module tb_adc_sample_scheduler;

   localparam int unsigned DW         = 12;
   localparam int unsigned PER        = 100;
   localparam int          ENG_BUSY   = 40;
   localparam int          ENG_B_BUSY = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, enable, single_shot, sample_ack, clear_err;
   logic          spi_ready, spi_start, sample_valid, overrun, timeout_err, busy;
   logic [DW-1:0] spi_data0, spi_data1, spi_data2, spi_data3;
   logic [DW-1:0] sample_ch0, sample_ch1, sample_ch2, sample_ch3;
   logic [2:0]    o_state;

   logic          ss_b, en_b, ack_b, clr_b;
   logic          ready_b, start_b, valid_b, ovr_b, to_err_b, busy_b;
   logic [DW-1:0] ch0_b, ch1_b, ch2_b, ch3_b;
   logic [2:0]    state_b;

   adc_sample_scheduler #(
      .PERIOD_CYC (PER),
      .TIMEOUT_CYC(64),
      .DATA_W     (DW)
   ) dut (
      .ref_clk(clk), .reset_n(reset_n), .enable(enable), .single_shot(single_shot),
      .spi_start(spi_start), .spi_ready(spi_ready),
      .spi_data0(spi_data0), .spi_data1(spi_data1), .spi_data2(spi_data2), .spi_data3(spi_data3),
      .sample_ch0(sample_ch0), .sample_ch1(sample_ch1), .sample_ch2(sample_ch2), .sample_ch3(sample_ch3),
      .sample_valid(sample_valid), .sample_ack(sample_ack), .overrun(overrun),
      .timeout_err(timeout_err), .clear_err(clear_err), .busy(busy), .o_state(o_state)
   );

   adc_sample_scheduler #(
      .PERIOD_CYC (PER),
      .TIMEOUT_CYC(16),
      .DATA_W     (DW)
   ) dut_to (
      .ref_clk(clk), .reset_n(reset_n), .enable(en_b), .single_shot(ss_b),
      .spi_start(start_b), .spi_ready(ready_b),
      .spi_data0(spi_data0), .spi_data1(spi_data1), .spi_data2(spi_data2), .spi_data3(spi_data3),
      .sample_ch0(ch0_b), .sample_ch1(ch1_b), .sample_ch2(ch2_b), .sample_ch3(ch3_b),
      .sample_valid(valid_b), .sample_ack(ack_b), .overrun(ovr_b),
      .timeout_err(to_err_b), .clear_err(clr_b), .busy(busy_b), .o_state(state_b)
   );

   // Engine models: ready drops on the negedge after spi_start and stays low for N cycles.
   int   eng_a_cnt = 0;
   int   eng_b_cnt = 0;
   logic eng_b_dead = 1'b0;
   int   n_start = 0;

   always @(negedge clk) begin
      if (spi_start && eng_a_cnt == 0) eng_a_cnt <= ENG_BUSY;
      else if (eng_a_cnt != 0)         eng_a_cnt <= eng_a_cnt - 1;
      if (start_b && !eng_b_dead && eng_b_cnt == 0) eng_b_cnt <= ENG_B_BUSY;
      else if (eng_b_cnt != 0)                      eng_b_cnt <= eng_b_cnt - 1;
      if (spi_start) n_start <= n_start + 1;
   end

   assign spi_ready = (eng_a_cnt == 0);
   assign ready_b   = (eng_b_cnt == 0);

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic stepn(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_ss();
      single_shot = 1'b1;
      step();
      single_shot = 1'b0;
   endtask

   task automatic pulse_ack();
      sample_ack = 1'b1;
      step();
      sample_ack = 1'b0;
   endtask

   task automatic pulse_clr();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 300 && busy; i++) step();
      chk(nm, busy, 1'b0);
   endtask

   typedef struct {
      logic          ack_pre;
      logic          clr_pre;
      logic [DW-1:0] d0, d1, d2, d3;
      logic          exp_valid;
      logic          exp_ov;
   } vec_t;

   vec_t vt [5];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int t, c1, c2, s0, n;
      vt[0] = '{1'b0, 1'b0, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b1, 1'b0};
      vt[1] = '{1'b0, 1'b0, 12'h001, 12'hFFF, 12'h800, 12'h7FF, 1'b1, 1'b1};
      vt[2] = '{1'b1, 1'b1, 12'h000, 12'h000, 12'h000, 12'h000, 1'b1, 1'b0};
      vt[3] = '{1'b1, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0};
      vt[4] = '{1'b0, 1'b0, 12'h5A5, 12'hA5A, 12'h0F0, 12'hF0F, 1'b1, 1'b1};

      reset_n = 1'b0; enable = 1'b0; single_shot = 1'b0; sample_ack = 1'b0; clear_err = 1'b0;
      ss_b = 1'b0; en_b = 1'b0; ack_b = 1'b0; clr_b = 1'b0;
      spi_data0 = '0; spi_data1 = '0; spi_data2 = '0; spi_data3 = '0;

      #12;
      chk("rst_state", o_state, 3'd0);
      chk("rst_start", spi_start, 1'b0);
      chk("rst_valid", sample_valid, 1'b0);
      chk("rst_ch0", sample_ch0, 12'h000);
      chk("rst_ovr", overrun, 1'b0);
      chk("rst_toerr", timeout_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      step();
      reset_n = 1'b1;
      stepn(2);

`ifdef ADC_SCHED_AVG_EN
      spi_data1 = 12'd200; spi_data2 = 12'd0; spi_data3 = 12'hFFF;
      s0 = n_start;
      pulse_ss();
      spi_data0 = 12'd100;
      for (int i = 1; i < 4; i++) begin
         step();
         for (t = 0; t < 200 && !spi_start; t++) step();
         chk("avg_chain_start", spi_start, 1'b1);
         chk("avg_no_valid_yet", sample_valid, 1'b0);
         case (i)
            1: spi_data0 = 12'd101;
            2: spi_data0 = 12'd102;
            default: spi_data0 = 12'd104;
         endcase
      end
      wait_idle("avg_idle");
      step();
      chk("avg_n_start", n_start - s0, 4);
      chk("avg_valid", sample_valid, 1'b1);
      chk("avg_ch0", sample_ch0, 12'd101);
      chk("avg_ch1", sample_ch1, 12'd200);
      chk("avg_ch3", sample_ch3, 12'hFFF);
`else
      for (int i = 0; i < 5; i++) begin
         if (vt[i].ack_pre) pulse_ack();
         if (vt[i].clr_pre) pulse_clr();
         spi_data0 = vt[i].d0; spi_data1 = vt[i].d1; spi_data2 = vt[i].d2; spi_data3 = vt[i].d3;
         pulse_ss();
         wait_idle("vec_idle");
         chk("vec_ch0", sample_ch0, vt[i].d0);
         chk("vec_ch1", sample_ch1, vt[i].d1);
         chk("vec_ch2", sample_ch2, vt[i].d2);
         chk("vec_ch3", sample_ch3, vt[i].d3);
         chk("vec_valid", sample_valid, vt[i].exp_valid);
         chk("vec_ovr", overrun, vt[i].exp_ov);
      end
      pulse_clr();
      chk("clr_ovr", overrun, 1'b0);
      pulse_ack();
      chk("ack_valid", sample_valid, 1'b0);

      // single_shot while busy is dropped
      s0 = n_start;
      pulse_ss();
      stepn(5);
      chk("busy_mid", busy, 1'b1);
      pulse_ss();
      wait_idle("busy_idle");
      stepn(150);
      chk("busy_one_start", n_start - s0, 1);

      // periodic run
      pulse_ack();
      spi_data0 = 12'h123; spi_data1 = 12'h456; spi_data2 = 12'h789; spi_data3 = 12'hABC;
      enable = 1'b1;
      for (t = 0; t < 150 && !spi_start; t++) step();
      chk("per_first_lat", t, PER);
      c1 = cyc;
      step();
      for (t = 0; t < 100 && !spi_ready; t++) step();
      chk("per_ready_rise", spi_ready, 1'b1);
      chk("per_capture_state", o_state, 3'd4);
      chk("per_valid_early", sample_valid, 1'b0);
      step();
      chk("per_valid", sample_valid, 1'b1);
      chk("per_ch0", sample_ch0, 12'h123);
      chk("per_ch1", sample_ch1, 12'h456);
      chk("per_ch2", sample_ch2, 12'h789);
      chk("per_ch3", sample_ch3, 12'hABC);
      spi_data0 = 12'hFED; spi_data1 = 12'hCBA; spi_data2 = 12'h987; spi_data3 = 12'h654;
      for (t = 0; t < 150 && !spi_start; t++) step();
      c2 = cyc;
      chk("per_interval", c2 - c1, PER);
      for (t = 0; t < 100 && o_state != 3'd4; t++) step();
      step();
      enable = 1'b0;
      chk("per2_valid", sample_valid, 1'b1);
      chk("per2_ovr", overrun, 1'b1);
      chk("per2_ch0", sample_ch0, 12'hFED);
      chk("per2_ch3", sample_ch3, 12'h654);
      pulse_clr();
      chk("per_clr_ovr", overrun, 1'b0);

      // timeout on the second instance
      eng_b_dead = 1'b1;
      ss_b = 1'b1; step(); ss_b = 1'b0;
      step();
      n = 0;
      while (state_b == 3'd2 && n < 100) begin
         n++;
         step();
      end
      chk("to_wait_cycles", n, 16);
      chk("to_fault_state", state_b, 3'd5);
      step();
      chk("to_err_set", to_err_b, 1'b1);
      chk("to_back_idle", state_b, 3'd0);
      chk("to_valid_kept", valid_b, 1'b0);
      chk("to_ch0_kept", ch0_b, 12'h000);
      eng_b_dead = 1'b0;
      ss_b = 1'b1; step(); ss_b = 1'b0;
      for (t = 0; t < 100 && busy_b; t++) step();
      chk("to_next_valid", valid_b, 1'b1);
      chk("to_next_ch0", ch0_b, 12'hFED);
      chk("to_err_sticky", to_err_b, 1'b1);
      clr_b = 1'b1; step(); clr_b = 1'b0;
      chk("to_err_clr", to_err_b, 1'b0);

      // async reset mid-WAIT_DONE
      pulse_ss();
      stepn(5);
      chk("rst2_in_wait_done", o_state, 3'd3);
      #3 reset_n = 1'b0;
      #1;
      chk("rst2_state", o_state, 3'd0);
      chk("rst2_valid", sample_valid, 1'b0);
      chk("rst2_ch1", sample_ch1, 12'h000);
      chk("rst2_busy", busy, 1'b0);
      chk("rst2_start", spi_start, 1'b0);
      #2 reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (o_state != 3'd0 || spi_start) n++;
      end
      chk("rst2_stays_idle", n, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
